// File: rtl/tk_mmu_pkg.sv
// Shared types for the data-side MMU.
//   dmmu_state_t : backing-port FSM states
//   wbuf_t       : one-entry write buffer {word address, data}
//   word_align() : clears the byte-offset bits of an address
package tk_mmu_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WR   = 2'd1,
    DM_RD   = 2'd2
  } dmmu_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } wbuf_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/tk_dmmu_tagram.sv
// Direct-mapped, one-word-per-line cache arrays (valid / tag / data).
//   i_clk, i_rst : clock, asynchronous active-high reset (clears valid bits)
//   i_inv        : synchronous clear of all valid bits; beats a same-edge write
//   i_raddr      : word address for the combinational lookup
//   o_hit/o_rdata: lookup result
//   i_we/i_waddr/i_wdata : single write port (fill or store-hit update)
module tk_dmmu_tagram
  import tk_mmu_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inv,
  input  logic [WORD_W-1:2] i_raddr,
  output logic              o_hit,
  output logic [WORD_W-1:0] o_rdata,
  input  logic              i_we,
  input  logic [WORD_W-1:2] i_waddr,
  input  logic [WORD_W-1:0] i_wdata
);

  localparam int unsigned LINES = 2 ** IDX_W;
  localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [WORD_W-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_ridx;
  logic [TAG_W-1:0] w_rtag;
  logic [IDX_W-1:0] w_widx;
  logic [TAG_W-1:0] w_wtag;

  assign w_ridx = i_raddr[IDX_W+1:2];
  assign w_rtag = i_raddr[WORD_W-1:IDX_W+2];
  assign w_widx = i_waddr[IDX_W+1:2];
  assign w_wtag = i_waddr[WORD_W-1:IDX_W+2];

  assign o_hit   = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);
  assign o_rdata = r_data[w_ridx];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else if (i_inv) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_widx] <= 1'b1;
    end
  end

  // Tag/data carry no reset: they are meaningless while valid is clear.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_tag[w_widx]  <= w_wtag;
      r_data[w_widx] <= i_wdata;
    end
  end

endmodule

// File: rtl/tk_dmmu.sv
// Data-side MMU / cache responder for the core's d_* port.
//   clk, rst          : clock, asynchronous active-high reset
//   d_addr/d_wr_data  : MEM-stage byte address and store data
//   d_rd/d_wr         : load / store request this cycle
//   d_rd_data         : registered load data, valid the cycle after an accepted load
//   d_miss            : access not accepted, core replays
//   d_segfault        : access illegal, never performed
//   seg_base/seg_limit: legal window [base, limit)
//   inv_all           : clear every valid bit at the next edge
//   mem_*             : req/ack backing port, one outstanding request
module tk_dmmu
  import tk_mmu_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wr_data,
  input  logic              d_rd,
  input  logic              d_wr,
  output logic [WORD_W-1:0] d_rd_data,
  output logic              d_miss,
  output logic              d_segfault,
  input  logic [WORD_W-1:0] seg_base,
  input  logic [WORD_W-1:0] seg_limit,
  input  logic              inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata
);

  dmmu_state_t       r_state;
  wbuf_t             r_wb;
  logic              r_wb_valid;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_rd_data;

  logic              w_seg;
  logic              w_ld;
  logic              w_st;
  logic              w_free;
  logic              w_conflict;
  logic              w_hit;
  logic [WORD_W-1:0] w_line;
  logic              w_ld_hit;
  logic              w_ld_miss;
  logic              w_st_acc;
  logic              w_fill;
  logic              w_tw_we;
  logic [WORD_W-1:2] w_tw_addr;
  logic [WORD_W-1:0] w_tw_data;

  // Segment check: simultaneous rd+wr and misaligned accesses are illegal too.
  assign w_seg = (d_rd || d_wr) &&
                 ((d_rd && d_wr) || (d_addr[1:0] != 2'b00) ||
                  (d_addr < seg_base) || (d_addr >= seg_limit));

  assign w_ld   = d_rd && !w_seg;
  assign w_st   = d_wr && !w_seg;
  assign w_free = (r_state == DM_IDLE) && !r_wb_valid;

  // A load to the word still sitting in the write buffer waits for the write.
  assign w_conflict = r_wb_valid && (r_wb.addr == word_align(d_addr));

  assign w_ld_hit  = w_ld && w_hit && !w_conflict;
  assign w_ld_miss = w_ld && !w_ld_hit;
  assign w_st_acc  = w_st && w_free;

  assign d_miss     = w_ld_miss || (w_st && !w_free);
  assign d_segfault = w_seg;

  // Fills only complete in RD and stores are only accepted in IDLE, so the
  // two sources of the single write port never collide.
  assign w_fill    = (r_state == DM_RD) && mem_ack;
  assign w_tw_we   = w_fill || (w_st_acc && w_hit);
  assign w_tw_addr = w_fill ? r_mem_addr[WORD_W-1:2] : d_addr[WORD_W-1:2];
  assign w_tw_data = w_fill ? mem_rdata : d_wr_data;

  tk_dmmu_tagram #(
    .IDX_W (IDX_W)
  ) u_tagram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inv   (inv_all),
    .i_raddr (d_addr[WORD_W-1:2]),
    .o_hit   (w_hit),
    .o_rdata (w_line),
    .i_we    (w_tw_we),
    .i_waddr (w_tw_addr),
    .i_wdata (w_tw_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (w_ld_hit) begin
      r_rd_data <= w_line;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DM_IDLE;
      r_wb       <= '0;
      r_wb_valid <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      unique case (r_state)
        DM_IDLE: begin
          if (w_st_acc) begin
            r_wb       <= '{addr: word_align(d_addr), data: d_wr_data};
            r_wb_valid <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b1;
            r_mem_addr <= word_align(d_addr);
            r_state    <= DM_WR;
          end else if (w_ld_miss && w_free) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= word_align(d_addr);
            r_state    <= DM_RD;
          end
        end
        DM_WR: begin
          if (mem_ack) begin
            r_wb_valid <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_state    <= DM_IDLE;
          end
        end
        DM_RD: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= DM_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= DM_IDLE;
        end
      endcase
    end
  end

  assign d_rd_data = r_rd_data;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_wb.data;

endmodule

// File: tb/tb_tk_dmmu.sv
// Scoreboard bench for tk_dmmu: stimulus pushes expected load data and
// expected backing requests; separate monitors pop and compare them.
module tb_tk_dmmu;

  logic        clk;
  logic        rst;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_rd_data;
  logic        d_miss;
  logic        d_segfault;
  logic [31:0] seg_base;
  logic [31:0] seg_limit;
  logic        inv_all;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  tk_dmmu #(.IDX_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .d_addr     (d_addr),
    .d_wr_data  (d_wr_data),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .d_rd_data  (d_rd_data),
    .d_miss     (d_miss),
    .d_segfault (d_segfault),
    .seg_base   (seg_base),
    .seg_limit  (seg_limit),
    .inv_all    (inv_all),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mexp_t;

  mexp_t       mq[$];
  logic [31:0] dq[$];
  logic [31:0] bmem [logic [31:0]];

  // Backing memory responder: auto mode acks after ack_delay cycles,
  // manual mode lets the stimulus drive ack/rdata directly.
  logic        auto_ack = 1'b1;
  int          ack_delay = 3;
  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  int          wait_cnt;

  assign mem_ack   = auto_ack ? resp_ack   : man_ack;
  assign mem_rdata = auto_ack ? resp_rdata : man_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    resp_ack   = 1'b0;
    resp_rdata = '0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!auto_ack || resp_ack || !mem_req) begin
        resp_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= ack_delay) begin
        resp_ack = 1'b1;
        if (mem_we) begin
          bmem[mem_addr] = mem_wdata;
          resp_rdata = '0;
        end else begin
          resp_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : 32'h0;
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  // Load-data monitor: a load accepted at an edge presents data after it.
  logic acc_q;
  always @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= d_rd && !d_miss && !d_segfault;
  end

  always @(negedge clk) begin
    if (acc_q) begin
      if (dq.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rd_data", d_rd_data, dq.pop_front());
      end
    end
  end

  // Backing-port monitor: new request compared against the queue, held
  // request compared against the expected transaction every cycle.
  logic  prev_req = 1'b0;
  mexp_t cur;
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (mq.size() == 0) begin
        chk("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
      end else begin
        cur = mq.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
        chk("mem_addr", mem_addr, cur.addr);
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
    end else if (mem_req && prev_req) begin
      chk("mem_addr_hold", mem_addr, cur.addr);
    end
    prev_req = mem_req;
  end

  task automatic drv(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    d_rd = rd; d_wr = wr; d_addr = a; d_wr_data = wd;
    #1;
  endtask

  task automatic idle_cyc();
    @(negedge clk);
    d_rd = 1'b0; d_wr = 1'b0;
    #1;
  endtask

  task automatic chk_resp(input string nm, input logic miss, input logic seg);
    chk({nm, "_miss"}, {31'd0, d_miss}, {31'd0, miss});
    chk({nm, "_seg"},  {31'd0, d_segfault}, {31'd0, seg});
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!mem_req) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: mem_req still 1 expected 0 after 64 cycles", nm);
    end
  endtask

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] wd);
    mexp_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endtask

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] a;
  } vec_t;

  vec_t segv [5] = '{
    '{1'b1, 1'b0, 32'h0000_0FFC},
    '{1'b1, 1'b0, 32'h0000_2000},
    '{1'b1, 1'b0, 32'h0000_1002},
    '{1'b1, 1'b1, 32'h0000_1000},
    '{1'b0, 1'b1, 32'h0000_2004}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bmem[32'h1000] = 32'hDEAD_BEEF;
    bmem[32'h1040] = 32'hA5A5_0040;
    bmem[32'h1080] = 32'hA5A5_0080;
    rst = 1'b1; d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wr_data = '0;
    seg_base = 32'h1000; seg_limit = 32'h2000; inv_all = 1'b0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_rd_data", d_rd_data, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk_resp("rst", 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // 1: cold load miss, fill, replay hit
    drv(1'b1, 1'b0, 32'h1000, 32'h0);
    chk_resp("t1_cold", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1000, 32'h0);
    idle_cyc();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    wait_idle("t1");
    drv(1'b1, 1'b0, 32'h1000, 32'h0);
    chk_resp("t1_replay", 1'b0, 1'b0);
    dq.push_back(32'hDEAD_BEEF);
    idle_cyc();

    // 2: segment faults, then the last legal word
    foreach (segv[i]) begin
      drv(segv[i].rd, segv[i].wr, segv[i].a, 32'h0BAD_0BAD);
      chk_resp($sformatf("t2_seg%0d", i), 1'b0, 1'b1);
    end
    idle_cyc();
    chk("t2_noreq", {31'd0, mem_req}, 32'd0);
    drv(1'b1, 1'b0, 32'h1FFC, 32'h0);
    chk_resp("t2_limit", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1FFC, 32'h0);
    idle_cyc();
    wait_idle("t2");

    // 3: store hit, busy store, blocked load, then hit on new data
    drv(1'b0, 1'b1, 32'h1000, 32'h1234_5678);
    chk_resp("t3_store", 1'b0, 1'b0);
    push_mem(1'b1, 32'h1000, 32'h1234_5678);
    drv(1'b0, 1'b1, 32'h1004, 32'h0000_1111);
    chk_resp("t3_busy_store", 1'b1, 1'b0);
    drv(1'b1, 1'b0, 32'h1000, 32'h0);
    chk_resp("t3_blocked_load", 1'b1, 1'b0);
    idle_cyc();
    wait_idle("t3");
    drv(1'b1, 1'b0, 32'h1000, 32'h0);
    chk_resp("t3_load", 1'b0, 1'b0);
    dq.push_back(32'h1234_5678);
    idle_cyc();

    // 4: fill pending, second miss blocked, hit served during RD
    ack_delay = 6;
    drv(1'b1, 1'b0, 32'h1040, 32'h0);
    chk_resp("t4_miss", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1040, 32'h0);
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("t4_miss2", 1'b1, 1'b0);
    drv(1'b1, 1'b0, 32'h1000, 32'h0);
    chk_resp("t4_hit_rd", 1'b0, 1'b0);
    dq.push_back(32'h1234_5678);
    idle_cyc();
    wait_idle("t4");
    drv(1'b1, 1'b0, 32'h1040, 32'h0);
    chk_resp("t4_replay", 1'b0, 1'b0);
    dq.push_back(32'hA5A5_0040);
    idle_cyc();

    // 5: inv_all on the fill-ack edge drops the fill
    auto_ack = 1'b0;
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("t5_miss", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1080, 32'h0);
    idle_cyc();
    idle_cyc();
    @(negedge clk);
    man_ack = 1'b1; man_rdata = 32'hA5A5_0080; inv_all = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; inv_all = 1'b0;
    #1;
    chk("t5_req_done", {31'd0, mem_req}, 32'd0);
    auto_ack = 1'b1; ack_delay = 2;
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("t5_dropped", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1080, 32'h0);
    idle_cyc();
    wait_idle("t5");
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("t5_replay", 1'b0, 1'b0);
    dq.push_back(32'hA5A5_0080);
    idle_cyc();

    // Stray ack with no request outstanding changes nothing
    auto_ack = 1'b0;
    @(negedge clk); man_ack = 1'b1; man_rdata = 32'hFFFF_0000;
    @(negedge clk); man_ack = 1'b0; #1;
    chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
    auto_ack = 1'b1;
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("stray_ack_hit", 1'b0, 1'b0);
    dq.push_back(32'hA5A5_0080);
    idle_cyc();

    // Store miss: written through, no allocate; later fill sees new data
    drv(1'b0, 1'b1, 32'h1100, 32'h0000_0055);
    chk_resp("nalloc_store", 1'b0, 1'b0);
    push_mem(1'b1, 32'h1100, 32'h0000_0055);
    idle_cyc();
    wait_idle("nalloc");
    drv(1'b1, 1'b0, 32'h1080, 32'h0);
    chk_resp("nalloc_old_hit", 1'b0, 1'b0);
    dq.push_back(32'hA5A5_0080);
    drv(1'b1, 1'b0, 32'h1100, 32'h0);
    chk_resp("nalloc_miss", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1100, 32'h0);
    idle_cyc();
    wait_idle("nalloc_fill");
    drv(1'b1, 1'b0, 32'h1100, 32'h0);
    chk_resp("nalloc_replay", 1'b0, 1'b0);
    dq.push_back(32'h0000_0055);
    idle_cyc();

    // 6: reset in the middle of a fill
    auto_ack = 1'b0;
    drv(1'b1, 1'b0, 32'h1040, 32'h0);
    chk_resp("t6_miss", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1040, 32'h0);
    idle_cyc();
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_mem_wdata", mem_wdata, 32'h0);
    chk("t6_rd_data", d_rd_data, 32'h0);
    chk_resp("t6_rst", 1'b0, 1'b0);
    idle_cyc();
    idle_cyc();
    @(negedge clk); rst = 1'b0;
    auto_ack = 1'b1;
    drv(1'b1, 1'b0, 32'h1100, 32'h0);
    chk_resp("t6_invalid", 1'b1, 1'b0);
    push_mem(1'b0, 32'h1100, 32'h0);
    idle_cyc();
    wait_idle("t6");
    drv(1'b1, 1'b0, 32'h1100, 32'h0);
    chk_resp("t6_replay", 1'b0, 1'b0);
    dq.push_back(32'h0000_0055);
    idle_cyc();
    idle_cyc();

    chk("dq_drained", dq.size(), 32'd0);
    chk("mq_drained", mq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
